// File: rtl/instr_fetch_ctrl.sv
// Fetch/decode/execute sequencer between the program counter + instruction ROM and the datapath.
// Moore machine: every output is a registered decode of the next state and the next IR contents.
`timescale 1ns/1ps

module instr_fetch_ctrl #(
  parameter int INSTR_W   = 16,
  parameter int D_ADDR_W  = 8,
  parameter int RF_ADDR_W = 4
) (
  input  logic                 Clock,
  input  logic                 Clr_n,
  input  logic [INSTR_W-1:0]   Instr,
  output logic                 PC_clr,
  output logic                 PC_up,
  output logic                 IR_ld,
  output logic [D_ADDR_W-1:0]  D_addr,
  output logic                 D_wr,
  output logic                 RF_s,
  output logic [RF_ADDR_W-1:0] RF_W_addr,
  output logic                 RF_W_en,
  output logic [RF_ADDR_W-1:0] RF_Ra_addr,
  output logic                 RF_Ra_en,
  output logic [RF_ADDR_W-1:0] RF_Rb_addr,
  output logic                 RF_Rb_en,
  output logic [2:0]           ALU_s0,
  output logic                 Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_STORE  = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_HALT   = 4'd8,
    S_NOOP   = 4'd9
  } state_t;

  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  state_t               state_r;
  state_t               state_next_s;
  logic [INSTR_W-1:0]   ir_r;
  logic [INSTR_W-1:0]   ir_next_s;
  logic [3:0]           op_cur_s;
  logic [3:0]           op_next_s;

  logic                 pc_clr_s;
  logic                 pc_up_s;
  logic                 ir_ld_s;
  logic [D_ADDR_W-1:0]  d_addr_s;
  logic                 d_wr_s;
  logic                 rf_s_s;
  logic [RF_ADDR_W-1:0] rf_w_addr_s;
  logic                 rf_w_en_s;
  logic [RF_ADDR_W-1:0] rf_ra_addr_s;
  logic                 rf_ra_en_s;
  logic [RF_ADDR_W-1:0] rf_rb_addr_s;
  logic                 rf_rb_en_s;
  logic [2:0]           alu_s0_s;
  logic                 halted_s;

  assign op_cur_s  = ir_r[INSTR_W-1 -: 4];
  assign op_next_s = ir_next_s[INSTR_W-1 -: 4];

  // Next-state and next-IR selection.
  always_comb begin
    state_next_s = state_r;
    ir_next_s    = ir_r;
    case (state_r)
      S_INIT:   state_next_s = S_FETCH;
      S_FETCH: begin
        state_next_s = S_DECODE;
        ir_next_s    = Instr;
      end
      S_DECODE: begin
        // NOOP and unused opcodes take an idle execute slot to keep the 3-cycle cadence.
        case (op_cur_s)
          OP_STORE: state_next_s = S_STORE;
          OP_LOAD:  state_next_s = S_LOAD_A;
          OP_ADD:   state_next_s = S_ADD;
          OP_SUB:   state_next_s = S_SUB;
          OP_HALT:  state_next_s = S_HALT;
          default:  state_next_s = S_NOOP;
        endcase
      end
      S_STORE:  state_next_s = S_FETCH;
      S_LOAD_A: state_next_s = S_LOAD_B;
      S_LOAD_B: state_next_s = S_FETCH;
      S_ADD:    state_next_s = S_FETCH;
      S_SUB:    state_next_s = S_FETCH;
      S_NOOP:   state_next_s = S_FETCH;
      S_HALT:   state_next_s = S_HALT;
      default:  state_next_s = S_INIT;
    endcase
  end

  // Output decode of the state/IR pair that becomes current on the next edge.
  always_comb begin
    pc_clr_s     = 1'b0;
    pc_up_s      = 1'b0;
    ir_ld_s      = 1'b0;
    d_wr_s       = 1'b0;
    rf_s_s       = 1'b0;
    rf_w_en_s    = 1'b0;
    rf_ra_en_s   = 1'b0;
    rf_rb_en_s   = 1'b0;
    alu_s0_s     = ALU_PASS;
    halted_s     = 1'b0;
    d_addr_s     = ir_next_s[4 +: D_ADDR_W];
    rf_w_addr_s  = ir_next_s[0 +: RF_ADDR_W];
    rf_rb_addr_s = ir_next_s[4 +: RF_ADDR_W];
    // STORE reads its source register from the low field; ADD/SUB use the high field.
    if (op_next_s == OP_STORE) begin
      rf_ra_addr_s = ir_next_s[0 +: RF_ADDR_W];
    end else begin
      rf_ra_addr_s = ir_next_s[8 +: RF_ADDR_W];
    end
    case (state_next_s)
      S_INIT:   pc_clr_s = 1'b1;
      S_FETCH: begin
        pc_up_s = 1'b1;
        ir_ld_s = 1'b1;
      end
      S_DECODE: pc_up_s = 1'b0;
      S_STORE: begin
        rf_ra_en_s = 1'b1;
        alu_s0_s   = ALU_PASS;
        d_wr_s     = 1'b1;
      end
      S_LOAD_A: rf_s_s = 1'b1;
      S_LOAD_B: begin
        rf_s_s    = 1'b1;
        rf_w_en_s = 1'b1;
      end
      S_ADD: begin
        rf_ra_en_s = 1'b1;
        rf_rb_en_s = 1'b1;
        alu_s0_s   = ALU_ADD;
        rf_w_en_s  = 1'b1;
      end
      S_SUB: begin
        rf_ra_en_s = 1'b1;
        rf_rb_en_s = 1'b1;
        alu_s0_s   = ALU_SUB;
        rf_w_en_s  = 1'b1;
      end
      S_HALT:   halted_s = 1'b1;
      S_NOOP:   pc_up_s  = 1'b0;
      default:  pc_clr_s = 1'b1;
    endcase
  end

  // State and instruction register.
  always_ff @(posedge Clock or negedge Clr_n) begin
    if (!Clr_n) begin
      state_r <= S_INIT;
      ir_r    <= {INSTR_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      ir_r    <= ir_next_s;
    end
  end

  // Registered outputs; reset values equal the INIT decode with a cleared IR.
  always_ff @(posedge Clock or negedge Clr_n) begin
    if (!Clr_n) begin
      PC_clr     <= 1'b1;
      PC_up      <= 1'b0;
      IR_ld      <= 1'b0;
      D_addr     <= {D_ADDR_W{1'b0}};
      D_wr       <= 1'b0;
      RF_s       <= 1'b0;
      RF_W_addr  <= {RF_ADDR_W{1'b0}};
      RF_W_en    <= 1'b0;
      RF_Ra_addr <= {RF_ADDR_W{1'b0}};
      RF_Ra_en   <= 1'b0;
      RF_Rb_addr <= {RF_ADDR_W{1'b0}};
      RF_Rb_en   <= 1'b0;
      ALU_s0     <= ALU_PASS;
      Halted     <= 1'b0;
    end else begin
      PC_clr     <= pc_clr_s;
      PC_up      <= pc_up_s;
      IR_ld      <= ir_ld_s;
      D_addr     <= d_addr_s;
      D_wr       <= d_wr_s;
      RF_s       <= rf_s_s;
      RF_W_addr  <= rf_w_addr_s;
      RF_W_en    <= rf_w_en_s;
      RF_Ra_addr <= rf_ra_addr_s;
      RF_Ra_en   <= rf_ra_en_s;
      RF_Rb_addr <= rf_rb_addr_s;
      RF_Rb_en   <= rf_rb_en_s;
      ALU_s0     <= alu_s0_s;
      Halted     <= halted_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: per-scenario tasks with inline comparisons.
// Control flags are compared as one vector {PC_clr,PC_up,IR_ld,D_wr,RF_s,RF_W_en,Ra_en,Rb_en,Halted}.
`timescale 1ns/1ps

module tb_instr_fetch_ctrl;

  logic        Clock;
  logic        Clr_n;
  logic [15:0] Instr;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, RF_Ra_en, RF_Rb_en, Halted;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [8:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [8:0] C_INIT   = 9'h100;
  localparam logic [8:0] C_FETCH  = 9'h0C0;
  localparam logic [8:0] C_IDLE   = 9'h000;
  localparam logic [8:0] C_LOAD_A = 9'h010;
  localparam logic [8:0] C_LOAD_B = 9'h018;
  localparam logic [8:0] C_ALU    = 9'h00E;
  localparam logic [8:0] C_STORE  = 9'h024;
  localparam logic [8:0] C_HALT   = 9'h001;

  assign ctl = {PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, RF_Ra_en, RF_Rb_en, Halted};

  instr_fetch_ctrl dut (
    .Clock(Clock), .Clr_n(Clr_n), .Instr(Instr),
    .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Ra_en(RF_Ra_en),
    .RF_Rb_addr(RF_Rb_addr), .RF_Rb_en(RF_Rb_en),
    .ALU_s0(ALU_s0), .Halted(Halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Clr_n = 1'b0;
    Instr = 16'h0000;
    tick();
    tick();
    n_checks++;
    if (ctl !== C_INIT) begin n_fail++; $display("FAIL reset_ctl got %h want %h", ctl, C_INIT); end
    n_checks++;
    if ({D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0} !== 23'h0) begin
      n_fail++; $display("FAIL reset_fields got %h want 0", {D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0});
    end
    Clr_n = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_INIT) begin n_fail++; $display("FAIL release_init got %h want %h", ctl, C_INIT); end
    tick();
    n_checks++;
    if (ctl !== C_FETCH) begin n_fail++; $display("FAIL first_fetch got %h want %h", ctl, C_FETCH); end
  endtask

  // Entered with the DUT sampled in FETCH; leaves it sampled in the next FETCH.
  task automatic test_load();
    Instr = 16'h2053;
    tick();
    Instr = 16'h0000;
    n_checks++;
    if (ctl !== C_IDLE) begin n_fail++; $display("FAIL load_decode got %h want %h", ctl, C_IDLE); end
    tick();
    n_checks++;
    if (ctl !== C_LOAD_A || D_addr !== 8'h05) begin
      n_fail++; $display("FAIL load_a got ctl=%h addr=%h want ctl=%h addr=05", ctl, D_addr, C_LOAD_A);
    end
    tick();
    n_checks++;
    if (ctl !== C_LOAD_B || D_addr !== 8'h05 || RF_W_addr !== 4'h3) begin
      n_fail++; $display("FAIL load_b got ctl=%h addr=%h w=%h want ctl=%h addr=05 w=3", ctl, D_addr, RF_W_addr, C_LOAD_B);
    end
    tick();
    n_checks++;
    if (ctl !== C_FETCH) begin n_fail++; $display("FAIL load_refetch got %h want %h", ctl, C_FETCH); end
  endtask

  task automatic test_alu(input logic [15:0] instr, input logic [2:0] alu,
                          input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rw);
    Instr = instr;
    tick();
    Instr = 16'h0000;
    tick();
    n_checks++;
    if (ctl !== C_ALU || ALU_s0 !== alu || RF_Ra_addr !== ra || RF_Rb_addr !== rb || RF_W_addr !== rw) begin
      n_fail++;
      $display("FAIL alu_%h got ctl=%h alu=%b ra=%h rb=%h rw=%h want ctl=%h alu=%b ra=%h rb=%h rw=%h",
               instr, ctl, ALU_s0, RF_Ra_addr, RF_Rb_addr, RF_W_addr, C_ALU, alu, ra, rb, rw);
    end
    tick();
    n_checks++;
    if (ctl !== C_FETCH) begin n_fail++; $display("FAIL alu_single_cycle got %h want %h", ctl, C_FETCH); end
  endtask

  task automatic test_store();
    Instr = 16'h10A7;
    tick();
    Instr = 16'h0000;
    tick();
    n_checks++;
    if (ctl !== C_STORE || D_addr !== 8'h0A || RF_Ra_addr !== 4'h7 || ALU_s0 !== 3'b000) begin
      n_fail++; $display("FAIL store got ctl=%h addr=%h ra=%h alu=%b want ctl=%h addr=0a ra=7 alu=000",
                         ctl, D_addr, RF_Ra_addr, ALU_s0, C_STORE);
    end
    tick();
    n_checks++;
    if (ctl !== C_FETCH) begin n_fail++; $display("FAIL store_single_cycle got %h want %h", ctl, C_FETCH); end
  endtask

  task automatic test_unused_opcode();
    Instr = 16'hF123;
    tick();
    Instr = 16'h0000;
    tick();
    n_checks++;
    if (ctl !== C_IDLE) begin n_fail++; $display("FAIL unused_op_exec got %h want %h", ctl, C_IDLE); end
    tick();
    n_checks++;
    if (ctl !== C_FETCH) begin n_fail++; $display("FAIL unused_op_refetch got %h want %h", ctl, C_FETCH); end
  endtask

  task automatic test_halt();
    int bad = 0;
    Instr = 16'h5000;
    tick();
    Instr = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ctl !== C_HALT) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL halt_hold got %0d bad cycles want 0", bad); end
    Clr_n = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_INIT) begin n_fail++; $display("FAIL halt_reset got %h want %h", ctl, C_INIT); end
    tick();
    Clr_n = 1'b1;
    tick();
    n_checks++;
    if (ctl !== C_FETCH) begin n_fail++; $display("FAIL halt_restart got %h want %h", ctl, C_FETCH); end
  endtask

  task automatic test_reset_mid_load();
    int wr = 0;
    Instr = 16'h2053;
    tick();
    tick();
    Instr = 16'h0000;
    n_checks++;
    if (ctl !== C_LOAD_A) begin n_fail++; $display("FAIL abort_setup got %h want %h", ctl, C_LOAD_A); end
    Clr_n = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_INIT) begin n_fail++; $display("FAIL abort_init got %h want %h", ctl, C_INIT); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (RF_W_en !== 1'b0 || D_wr !== 1'b0) wr++;
    end
    Clr_n = 1'b1;
    tick();
    if (RF_W_en !== 1'b0 || D_wr !== 1'b0) wr++;
    n_checks++;
    if (wr !== 0) begin n_fail++; $display("FAIL abort_no_write got %0d write cycles want 0", wr); end
  endtask

  // Entered sampled in FETCH with NOOPs on the bus; spans a full PC wrap.
  task automatic test_back_to_back_noop();
    int pulses = 0;
    int last = -3;
    int gap_bad = 0;
    int wr = 0;
    Instr = 16'h0000;
    for (int i = 0; i < 384; i++) begin
      if (PC_up === 1'b1) begin
        pulses++;
        if (i - last !== 3) gap_bad++;
        last = i;
      end
      if (RF_W_en !== 1'b0 || D_wr !== 1'b0) wr++;
      tick();
    end
    n_checks++;
    if (pulses !== 128) begin n_fail++; $display("FAIL noop_pulses got %0d want 128", pulses); end
    n_checks++;
    if (gap_bad !== 0) begin n_fail++; $display("FAIL noop_spacing got %0d bad gaps want 0", gap_bad); end
    n_checks++;
    if (wr !== 0) begin n_fail++; $display("FAIL noop_no_write got %0d want 0", wr); end
  endtask

  initial begin
    Clr_n = 1'b0;
    Instr = 16'h0000;
    test_reset();
    test_load();
    test_alu(16'h3124, 3'b001, 4'h1, 4'h2, 4'h4);
    test_alu(16'h4567, 3'b010, 4'h5, 4'h6, 4'h7);
    test_store();
    test_unused_opcode();
    test_halt();
    test_reset_mid_load();
    test_back_to_back_noop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
